// File: rtl/inject_queue.sv
// Router-side receiver for the local-unit injection port: buffers pushed flits
// in a FIFO, drives inject_avail back-pressure and presents flits first-word fall-through.
module inject_queue #(
  parameter int FLIT_W       = 256,
  parameter int DEPTH        = 16,
  parameter int AVAIL_MARGIN = 4,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        inject,
  input  logic                     inject_valid,
  output logic                     inject_avail,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Handshakes: the inject side has no ready; a flit is taken whenever
  // inject_valid is high and a slot is free (or freed by a same-cycle pop),
  // otherwise it is dropped and counted. The output side transfers a flit on
  // every cycle where out_valid and out_ready are both high; out_valid never
  // depends on out_ready.

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  count;
  logic [OCC_W-1:0]  count_next;
  logic [OCC_W-1:0]  free_next;
  logic              pop;
  logic              push_ok;
  logic              drop;

  assign out_valid = (count != '0);
  assign out_flit  = mem[rd_ptr];
  assign occupancy = count;

  always_comb begin
    pop        = out_valid & out_ready;
    push_ok    = inject_valid & ((count < OCC_W'(DEPTH)) | pop);
    drop       = inject_valid & ~push_ok;
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + OCC_W'(1);
      2'b01:   count_next = count - OCC_W'(1);
      default: count_next = count;
    endcase
    free_next  = OCC_W'(DEPTH) - count_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inject_avail <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      // The margin absorbs the local unit's reaction latency to avail falling.
      inject_avail <= (free_next > OCC_W'(AVAIL_MARGIN));
      if (drop && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + CNT_W'(1);
    end
  end

  // Storage is not reset; stale contents are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= inject;
  end

endmodule

// File: tb/tb_inject_queue.sv
// Self-checking bench for inject_queue: a reference model at the falling edge
// keeps an expected-flit queue and state, plus directed scenario checks.
module tb_inject_queue;

  localparam int FLIT_W       = 16;
  localparam int DEPTH        = 16;
  localparam int AVAIL_MARGIN = 4;
  localparam int CNT_W        = 16;
  localparam int OCC_W        = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [FLIT_W-1:0] inject;
  logic              inject_valid;
  logic              inject_avail;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  overflow_cnt;

  inject_queue #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .AVAIL_MARGIN(AVAIL_MARGIN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .inject(inject), .inject_valid(inject_valid),
    .inject_avail(inject_avail), .out_flit(out_flit), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy), .overflow_cnt(overflow_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else checks_passed++;
  endtask

  // scoreboard / reference model
  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] pop_log[$];
  bit model_on = 1'b0;
  int m_count  = 0;
  int m_ovf    = 0;
  bit m_avail  = 1'b0;

  always @(negedge clk) begin
    bit m_pop;
    bit m_push;
    logic [FLIT_W-1:0] e;
    if (model_on) begin
      check("occupancy", 32'(occupancy), 32'(m_count));
      check("out_valid", 32'(out_valid), 32'(m_count != 0));
      check("inject_avail", 32'(inject_avail), 32'(m_avail));
      check("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
    end
    if (rst) begin
      m_count  = 0;
      m_ovf    = 0;
      m_avail  = 1'b0;
      exp_q.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      m_pop  = (m_count != 0) && out_ready;
      m_push = inject_valid && ((m_count < DEPTH) || m_pop);
      if (m_pop) begin
        e = exp_q.pop_front();
        check("out_flit", 32'(out_flit), 32'(e));
        pop_log.push_back(out_flit);
      end
      if (m_push) exp_q.push_back(inject);
      if (inject_valid && !m_push && (m_ovf < (1 << CNT_W) - 1)) m_ovf++;
      m_count = m_count + int'(m_push) - int'(m_pop);
      m_avail = (DEPTH - m_count) > AVAIL_MARGIN;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [FLIT_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      inject       = base + FLIT_W'(i);
      inject_valid = 1'b1;
      step();
    end
    inject_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    for (int c = 0; c < 100; c++) begin
      if (!out_valid) break;
      out_ready = toggle ? ((c % 2) == 0) : 1'b1;
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int sent;
    rst = 1'b1; inject = '0; inject_valid = 1'b0; out_ready = 1'b0;

    // reset release
    for (int i = 0; i < 3; i++) step();
    check("rst_avail", 32'(inject_avail), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_ovf", 32'(overflow_cnt), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_avail", 32'(inject_avail), 32'd1);

    // single flit with latency 1
    inject = 16'h00A5; inject_valid = 1'b1; out_ready = 1'b1;
    step();
    inject_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_flit", 32'(out_flit), 32'h00A5);
    step();
    check("single_gone", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // avail threshold
    for (int i = 0; i < 12; i++) begin
      inject = FLIT_W'(16'h0010 + i); inject_valid = 1'b1;
      step();
      if (i < 11) check("thr_avail_hi", 32'(inject_avail), 32'd1);
    end
    inject_valid = 1'b0;
    check("thr_avail_lo", 32'(inject_avail), 32'd0);
    check("thr_occ12", 32'(occupancy), 32'd12);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("thr_occ11", 32'(occupancy), 32'd11);
    check("thr_avail_back", 32'(inject_avail), 32'd1);
    drain(1'b0);

    // overflow, then full queue with simultaneous push and pop
    push_n(16, 16'h0100);
    push_n(3, 16'h0200);
    check("ovf_cnt3", 32'(overflow_cnt), 32'd3);
    check("ovf_occ16", 32'(occupancy), 32'd16);
    pop_log.delete();
    inject = 16'h0077; inject_valid = 1'b1; out_ready = 1'b1;
    step();
    inject_valid = 1'b0; out_ready = 1'b0;
    check("full_pp_occ", 32'(occupancy), 32'd16);
    check("full_pp_ovf", 32'(overflow_cnt), 32'd3);
    drain(1'b0);
    check("full_pp_len", 32'(pop_log.size()), 32'd17);
    check("full_pp_first", 32'(pop_log[0]), 32'h0100);
    check("full_pp_16th", 32'(pop_log[15]), 32'h010F);
    check("full_pp_77", 32'(pop_log[16]), 32'h0077);

    // wrap-around stream, honouring inject_avail, out_ready toggling
    pop_log.delete();
    sent = 0;
    for (int c = 0; c < 300 && sent < 40; c++) begin
      out_ready    = (c % 2) == 0;
      inject       = FLIT_W'(sent);
      inject_valid = inject_avail;
      step();
      if (inject_valid) sent++;
    end
    inject_valid = 1'b0;
    check("stream_sent", 32'(sent), 32'd40);
    drain(1'b1);
    check("stream_len", 32'(pop_log.size()), 32'd40);
    check("stream_last", 32'(pop_log[39]), 32'd39);
    check("stream_ovf", 32'(overflow_cnt), 32'd3);

    // mid-operation reset
    push_n(5, 16'h0300);
    check("mid_occ5", 32'(occupancy), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_occ0", 32'(occupancy), 32'd0);
    check("mid_valid0", 32'(out_valid), 32'd0);
    check("mid_ovf0", 32'(overflow_cnt), 32'd0);
    step();
    inject = 16'h0001; inject_valid = 1'b1;
    step();
    inject_valid = 1'b0;
    check("post_mid_valid", 32'(out_valid), 32'd1);
    check("post_mid_flit", 32'(out_flit), 32'h0001);
    pop_log.delete();
    drain(1'b0);
    check("post_mid_len", 32'(pop_log.size()), 32'd1);
    check("post_mid_first", 32'(pop_log[0]), 32'h0001);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inject_queue.md
Name: inject_queue

Overview:
- Router-side receiving end of the local-unit injection interface (inject / inject_valid / inject_avail), one instance per injection direction.
- Accepts flits pushed by the local unit and buffers them in a FIFO.
- Drives the avail back-pressure signal with a safety margin that covers the local unit's reaction latency.
- Presents the buffered flits to the router switch allocator over a valid/ready handshake.

Parameters:
- FLIT_W, 256, flit width in bits; the instantiator sets it to FLIT_SIZE.
- DEPTH, 16, FIFO depth in flits; must be a power of 2 and at least 4.
- AVAIL_MARGIN, 4, minimum free slots required to keep inject_avail high; must be less than DEPTH.
- CNT_W, 16, width of the overflow drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- inject  in  FLIT_W  flit from the local unit
- inject_valid  in  1  flit present this cycle; no ready, push is fire-and-forget
- inject_avail  out  1  local unit may keep injecting
- out_flit  out  FLIT_W  head-of-queue flit to the router
- out_valid  out  1  queue not empty
- out_ready  in  1  router consumes out_flit this cycle
- occupancy  out  $clog2(DEPTH)+1  current number of stored flits
- overflow_cnt  out  CNT_W  number of dropped pushes, saturating

Behaviour:
- Reset is synchronous: while rst=1, on every clk edge:
  - rd_ptr, wr_ptr and count go to 0;
  - inject_avail=0, overflow_cnt=0.
  - out_valid=0 because count=0.
  - Memory contents are don't-care.
- Event definitions:
  - pop = out_valid & out_ready.
  - push_ok = inject_valid & (count < DEPTH | pop).
  - drop = inject_valid & ~push_ok.
- push_ok:
  - writes mem[wr_ptr] <= inject;
  - wr_ptr advances modulo DEPTH, wrapping naturally.
- pop:
  - rd_ptr advances modulo DEPTH.
- count_next = count + push_ok - pop.
  - Simultaneous push and pop leaves count unchanged.
  - A push into a full queue with a same-cycle pop is accepted.
- drop:
  - overflow_cnt increments by 1 and saturates at all-ones.
  - The flit is discarded.
  - This is an error condition; asserting inject_valid while inject_avail=0 is otherwise legal.
- Output path is first-word fall-through:
  - out_flit = mem[rd_ptr], out_valid = (count != 0).
  - A flit pushed in cycle N is visible on out_flit/out_valid in cycle N+1. Latency is 1, including a push into an empty queue.
  - out_flit is don't-care when out_valid=0.
  - out_ready while out_valid=0 has no effect.
- occupancy = count, registered.
- inject_avail is registered: inject_avail <= ((DEPTH - count_next) > AVAIL_MARGIN).
  - It is therefore first high on the cycle after rst deasserts.
  - It changes one cycle after the count change that causes it.
- Ordering is strict FIFO; no reordering, duplication or loss except counted drops.
- rst asserted mid-operation discards all stored flits with no partial output. overflow_cnt is cleared.

Test Plan:
- Use DEPTH=16, AVAIL_MARGIN=4, out_ready=0 unless stated.
- Reset release: hold rst 3 cycles, then release -> inject_avail=0 during reset, 1 on the first cycle after; out_valid=0; occupancy=0; overflow_cnt=0.
- Single flit: push 0xA5 in cycle N with out_ready=1 -> out_valid=1, out_flit=0xA5 in N+1; popped in N+1; out_valid=0 in N+2.
- Threshold: push 12 flits back-to-back -> inject_avail stays 1 through the 11th push; goes 0 the cycle after the 12th push (occupancy=12). One pop -> occupancy=11 and inject_avail=1 the next cycle.
- Overflow:
  - Fill to 16, then push 3 more -> overflow_cnt=3 and occupancy=16.
  - Drain all -> out_flit sequence equals the first 16 pushed values in order.
- Full with simultaneous push+pop: at occupancy=16 push 0x77 with out_ready=1 -> accepted; occupancy stays 16; overflow_cnt unchanged; 0x77 emerges 16th after.
- Wrap-around and mid-reset:
  - Stream 40 incrementing flits with out_ready toggling 1,0 each cycle -> output sequence 0..39, no drops.
  - Assert rst with occupancy=5 -> occupancy=0 and out_valid=0 next cycle; post-reset push 0x01 -> it is the first flit out.
